dice: RTL and testbench

- Electronic die for an FPGA board.
- A free-running modulo-6 counter ("roll") advances every clock. When the asynchronous button input number_catch rises, the current face value 1..6 is latched and shown on a single 7-segment digit.
- Top-level leaf between the board button/clock and the segment pins.

---
 rtl/dice_pkg.sv | 29 ++
 rtl/seg7_face_decoder.sv | 30 +++
 rtl/dice.sv | 53 +++++
 tb/tb_dice.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/dice_pkg.sv
// Shared types and constants for the electronic die.
//   face_t : 3-bit face value (0 = blank, 1..6 = die faces)
//   seg_t  : 7-segment pattern, bit order {g,f,e,d,c,b,a}, active-high
package dice_pkg;

   typedef logic [2:0] face_t;
   typedef logic [6:0] seg_t;

   localparam face_t FACE_BLANK = 3'd0;
   localparam face_t FACE_MIN   = 3'd1;
   localparam face_t FACE_MAX   = 3'd6;

   localparam seg_t SEG_BLANK = 7'h00;
   localparam seg_t SEG_1     = 7'h06;
   localparam seg_t SEG_2     = 7'h5B;
   localparam seg_t SEG_3     = 7'h4F;
   localparam seg_t SEG_4     = 7'h66;
   localparam seg_t SEG_5     = 7'h6D;
   localparam seg_t SEG_6     = 7'h7D;

   // Next roll value; any value outside 1..6 recovers to 1.
   function automatic face_t next_roll(input face_t cur);
      if (cur >= FACE_MAX || cur < FACE_MIN)
         return FACE_MIN;
      else
         return cur + 3'd1;
   endfunction

endpackage

// File: rtl/seg7_face_decoder.sv
// Combinational face -> 7-segment decoder.
//   face     : latched face value (0 and 7 display blank)
//   segments : pattern {g..a}; inverted when SEG_ACTIVE_LOW = 1
module seg7_face_decoder
   import dice_pkg::*;
#(
   parameter bit SEG_ACTIVE_LOW = 1'b0
) (
   input  face_t      face,
   output logic [6:0] segments
);

   seg_t pattern;

   always_comb begin
      pattern = SEG_BLANK;
      case (face)
         3'd1:    pattern = SEG_1;
         3'd2:    pattern = SEG_2;
         3'd3:    pattern = SEG_3;
         3'd4:    pattern = SEG_4;
         3'd5:    pattern = SEG_5;
         3'd6:    pattern = SEG_6;
         default: pattern = SEG_BLANK;
      endcase
   end

   assign segments = SEG_ACTIVE_LOW ? ~pattern : pattern;

endmodule

// File: rtl/dice.sv
// Electronic die: free-running 1..6 roll counter, captured on each
// rising edge of the (asynchronous) catch button and shown on one
// 7-segment digit.
//   clk          : system clock, rising edge
//   reset        : asynchronous, active-low
//   number_catch : button level, asynchronous to clk
//   segments     : 7-segment drive {g,f,e,d,c,b,a}
module dice
   import dice_pkg::*;
#(
   parameter bit SEG_ACTIVE_LOW = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       number_catch,
   output logic [6:0] segments
);

   face_t roll;
   face_t face;
   logic  s1, s2, s3;
   logic  catch_pulse;

   // One-cycle pulse per synchronised rising edge of the button.
   assign catch_pulse = s2 & ~s3;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         roll <= FACE_MIN;
         s1   <= 1'b0;
         s2   <= 1'b0;
         s3   <= 1'b0;
         face <= FACE_BLANK;
      end else begin
         roll <= next_roll(roll);
         s1   <= number_catch;
         s2   <= s1;
         s3   <= s2;
         // Captures the pre-edge roll value, so a catch coinciding
         // with the 6->1 wrap shows 6.
         if (catch_pulse)
            face <= roll;
      end
   end

   seg7_face_decoder #(
      .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
   ) u_decoder (
      .face    (face),
      .segments(segments)
   );

endmodule

// File: tb/tb_dice.sv
// Self-checking bench for dice: stimulus pushes the expected segment
// pattern when a displayed face change is due; a monitor pops and
// compares on every segments change of both polarity instances.
module tb_dice;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       number_catch = 1'b0;
   logic [6:0] seg;
   logic [6:0] seg_n;

   int errors = 0;
   int checks = 0;

   logic [6:0] exp_q[$];
   logic [2:0] r = 3'd1;
   logic [2:0] shown = 3'd0;
   bit         mon_en = 1'b0;

   always #5 clk = ~clk;

   dice dut (
      .clk         (clk),
      .reset       (reset),
      .number_catch(number_catch),
      .segments    (seg)
   );

   dice #(.SEG_ACTIVE_LOW(1'b1)) dut_n (
      .clk         (clk),
      .reset       (reset),
      .number_catch(number_catch),
      .segments    (seg_n)
   );

   function automatic logic [6:0] seg_of(input logic [2:0] f);
      case (f)
         3'd1:    return 7'h06;
         3'd2:    return 7'h5B;
         3'd3:    return 7'h4F;
         3'd4:    return 7'h66;
         3'd5:    return 7'h6D;
         3'd6:    return 7'h7D;
         default: return 7'h00;
      endcase
   endfunction

   function automatic logic [2:0] adv(input logic [2:0] v, input int unsigned n);
      logic [2:0] x;
      x = v;
      for (int unsigned i = 0; i < n; i++)
         x = (x == 3'd6) ? 3'd1 : x + 3'd1;
      return x;
   endfunction

   task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance one clock; sample 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
      if (reset) r = adv(r, 1);
      check("roll", {4'b0, dut.roll}, {4'b0, r});
   endtask

   // Raise the button between edges; capture happens two edges later
   // with the roll value present before that edge.
   task automatic raise();
      logic [2:0] f;
      number_catch = 1'b1;
      f = adv(r, 2);
      if (f != shown) begin
         exp_q.push_back(seg_of(f));
         shown = f;
      end
   endtask

   task automatic lower();
      number_catch = 1'b0;
      repeat (3) tick();
   endtask

   // Monitor: every segments change must match the next queued pattern.
   initial begin
      logic [6:0] e;
      wait (mon_en);
      forever begin
         @(seg or seg_n);
         #1;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_change: got %h / %h, expected no change at %0t",
                     seg, seg_n, $time);
         end else begin
            e = exp_q.pop_front();
            check("seg", seg, e);
            check("seg_n", seg_n, ~e);
         end
      end
   end

   initial begin
      // Reset held with the button toggling.
      for (int k = 0; k < 3; k++) begin
         number_catch = ~number_catch;
         @(posedge clk);
         #1;
         check("reset_seg", seg, 7'h00);
         check("reset_seg_n", seg_n, 7'h7F);
         check("reset_roll", {4'b0, dut.roll}, 7'd1);
         check("reset_face", {4'b0, dut.face}, 7'd0);
      end
      number_catch = 1'b0;
      mon_en = 1'b1;
      reset = 1'b1;

      // Free-running roll with no catch: 1,2,..,6,1,...
      repeat (14) tick();
      check("roll_after_14", {4'b0, dut.roll}, 7'd3);

      // Single catch with roll=3 before E0 -> face 5, then hold high.
      raise();
      repeat (22) tick();
      check("single_catch", seg, 7'h6D);

      // Catch coinciding with the 6->1 wrap shows 6.
      lower();
      for (int i = 0; i < 6 && r != 3'd4; i++) tick();
      raise();
      repeat (4) tick();
      check("wrap_capture", seg, 7'h7D);

      // Repeated catches, 10-cycle period.
      lower();
      for (int k = 0; k < 6; k++) begin
         raise();
         repeat (5) tick();
         number_catch = 1'b0;
         repeat (5) tick();
      end

      // Show face 4, then reset between clock edges.
      lower();
      for (int i = 0; i < 6 && r != 3'd2; i++) tick();
      raise();
      repeat (4) tick();
      check("face4", seg, 7'h66);
      #3;
      if (shown != 3'd0) exp_q.push_back(7'h00);
      shown = 3'd0;
      reset = 1'b0;
      number_catch = 1'b0;
      #1;
      check("async_reset_seg", seg, 7'h00);
      check("async_reset_seg_n", seg_n, 7'h7F);
      check("async_reset_face", {4'b0, dut.face}, 7'd0);
      check("async_reset_roll", {4'b0, dut.roll}, 7'd1);
      @(posedge clk);
      #1;
      reset = 1'b1;
      r = 3'd1;
      check("restart_roll", {4'b0, dut.roll}, 7'd1);
      repeat (4) tick();
      check("restart_seg", seg, 7'h00);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL pending_updates: got %0d outstanding, expected 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
